// File: rtl/decode.sv
// RV32I decode stage: instruction decode, immediate generation, 32x32 register file.
// Optional DECODE_RF_BYPASS_EN makes the register file write-first.
package definitions_pkg;
  typedef logic signed [31:0] word_st;
  typedef logic [31:0] word_32ut;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef struct packed {
    word_32ut   rs1_data;
    word_32ut   rs2_data;
    word_st     imm;
    word_32ut   pc;
    word_32ut   pc_next_4;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [3:0] alu_ctrl;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] result_src;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       illegal;
  } dc_ex_t;
endpackage

module decode
  import definitions_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_dc_i,
  input  logic [31:0] pc_dc_i,
  input  logic [31:0] pc_next_4_dc_i,
  input  logic        flush_ex_i,
  input  logic        reg_write_wb_i,
  input  logic [4:0]  rd_wb_i,
  input  logic [31:0] result_wb_i,
  output logic [4:0]  rs1_dc_o,
  output logic [4:0]  rs2_dc_o,
  output logic [31:0] rs1_data_ex_o,
  output logic [31:0] rs2_data_ex_o,
  output logic [31:0] imm_ex_o,
  output logic [31:0] pc_ex_o,
  output logic [31:0] pc_next_4_ex_o,
  output logic [4:0]  rs1_ex_o,
  output logic [4:0]  rs2_ex_o,
  output logic [4:0]  rd_ex_o,
  output logic [2:0]  funct3_ex_o,
  output logic [3:0]  alu_ctrl_ex_o,
  output logic        alu_src_a_ex_o,
  output logic        alu_src_b_ex_o,
  output logic [1:0]  result_src_ex_o,
  output logic        reg_write_ex_o,
  output logic        mem_write_ex_o,
  output logic        branch_ex_o,
  output logic        jump_ex_o,
  output logic        jalr_ex_o,
  output logic        illegal_ex_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;

  assign instr     = instr_dc_i;
  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7_b5 = instr[30];
  assign rs1       = instr[19:15];
  assign rs2       = instr[24:20];
  assign rd        = instr[11:7];

  assign rs1_dc_o = rs1;
  assign rs2_dc_o = rs2;

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_branch, is_load, is_store;
  logic is_opimm, is_op, is_bubble;

  assign is_lui    = opcode == OPC_LUI;
  assign is_auipc  = opcode == OPC_AUIPC;
  assign is_jal    = opcode == OPC_JAL;
  assign is_jalr   = opcode == OPC_JALR;
  assign is_branch = opcode == OPC_BRANCH;
  assign is_load   = opcode == OPC_LOAD;
  assign is_store  = opcode == OPC_STORE;
  assign is_opimm  = opcode == OPC_OPIMM;
  assign is_op     = opcode == OPC_OP;
  assign is_bubble = instr == 32'd0;

  word_st imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};

  // SUB only exists for register-register ops; SRA for both forms
  function automatic logic [3:0] arith_op(
    input logic [2:0] f3,
    input logic       b5,
    input logic       reg_reg
  );
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = (reg_reg && b5) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = b5 ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [31:0] rf [32];
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_en;

  assign wb_en = reg_write_wb_i && (rd_wb_i != 5'd0);

`ifdef DECODE_RF_BYPASS_EN
  always_comb begin
    rs1_data = rf[rs1];
    rs2_data = rf[rs2];
    if (wb_en && rd_wb_i == rs1) rs1_data = result_wb_i;
    if (wb_en && rd_wb_i == rs2) rs2_data = result_wb_i;
    if (rs1 == 5'd0) rs1_data = '0;
    if (rs2 == 5'd0) rs2_data = '0;
  end
`else
  always_comb begin
    rs1_data = (rs1 == 5'd0) ? '0 : rf[rs1];
    rs2_data = (rs2 == 5'd0) ? '0 : rf[rs2];
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 32; k++) rf[k] <= '0;
    end else if (wb_en) begin
      rf[rd_wb_i] <= result_wb_i;
    end
  end

  dc_ex_t dc;

  always_comb begin
    dc           = '0;
    dc.rs1_data  = rs1_data;
    dc.rs2_data  = rs2_data;
    dc.pc        = pc_dc_i;
    dc.pc_next_4 = pc_next_4_dc_i;
    dc.rs1       = rs1;
    dc.rs2       = rs2;
    dc.rd        = rd;
    dc.funct3    = funct3;
    unique case (1'b1)
      is_lui: begin
        dc.imm        = imm_u;
        dc.alu_ctrl   = ALU_PASSB;
        dc.alu_src_b  = 1'b1;
        dc.reg_write  = 1'b1;
      end
      is_auipc: begin
        dc.imm        = imm_u;
        dc.alu_src_a  = 1'b1;
        dc.alu_src_b  = 1'b1;
        dc.reg_write  = 1'b1;
      end
      is_jal: begin
        dc.imm        = imm_j;
        dc.alu_src_a  = 1'b1;
        dc.alu_src_b  = 1'b1;
        dc.result_src = RES_PC4;
        dc.reg_write  = 1'b1;
        dc.jump       = 1'b1;
      end
      is_jalr: begin
        dc.imm        = imm_i;
        dc.alu_src_b  = 1'b1;
        dc.result_src = RES_PC4;
        dc.reg_write  = 1'b1;
        dc.jalr       = 1'b1;
      end
      is_branch: begin
        dc.imm        = imm_b;
        dc.alu_ctrl   = ALU_SUB;
        dc.branch     = 1'b1;
      end
      is_load: begin
        dc.imm        = imm_i;
        dc.alu_src_b  = 1'b1;
        dc.result_src = RES_MEM;
        dc.reg_write  = 1'b1;
      end
      is_store: begin
        dc.imm        = imm_s;
        dc.alu_src_b  = 1'b1;
        dc.mem_write  = 1'b1;
      end
      is_opimm: begin
        dc.imm        = imm_i;
        dc.alu_ctrl   = arith_op(funct3, funct7_b5, 1'b0);
        dc.alu_src_b  = 1'b1;
        dc.reg_write  = 1'b1;
      end
      is_op: begin
        dc.alu_ctrl   = arith_op(funct3, funct7_b5, 1'b1);
        dc.reg_write  = 1'b1;
      end
      is_bubble: begin
        dc.illegal    = 1'b0;
      end
      default: begin
        dc.illegal    = 1'b1;
      end
    endcase
  end

  dc_ex_t ex_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q <= '0;
    end else if (flush_ex_i) begin
      ex_q <= '0;
    end else begin
      ex_q <= dc;
    end
  end

  assign rs1_data_ex_o   = ex_q.rs1_data;
  assign rs2_data_ex_o   = ex_q.rs2_data;
  assign imm_ex_o        = ex_q.imm;
  assign pc_ex_o         = ex_q.pc;
  assign pc_next_4_ex_o  = ex_q.pc_next_4;
  assign rs1_ex_o        = ex_q.rs1;
  assign rs2_ex_o        = ex_q.rs2;
  assign rd_ex_o         = ex_q.rd;
  assign funct3_ex_o     = ex_q.funct3;
  assign alu_ctrl_ex_o   = ex_q.alu_ctrl;
  assign alu_src_a_ex_o  = ex_q.alu_src_a;
  assign alu_src_b_ex_o  = ex_q.alu_src_b;
  assign result_src_ex_o = ex_q.result_src;
  assign reg_write_ex_o  = ex_q.reg_write;
  assign mem_write_ex_o  = ex_q.mem_write;
  assign branch_ex_o     = ex_q.branch;
  assign jump_ex_o       = ex_q.jump;
  assign jalr_ex_o       = ex_q.jalr;
  assign illegal_ex_o    = ex_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: directed instructions, queued expectations,
// negedge monitor comparing the whole execute register.
module tb_decode;

  typedef struct packed {
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcn;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  aluc;
    logic        sa;
    logic        sb;
    logic [1:0]  rsrc;
    logic        rw;
    logic        mw;
    logic        br;
    logic        j;
    logic        jr;
    logic        ill;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic [31:0] pcn_in = '0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  logic [4:0]  rs1_dc, rs2_dc;
  logic [31:0] rs1d, rs2d, imm, pc_o, pcn_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [2:0]  f3_o;
  logic [3:0]  aluc_o;
  logic        sa_o, sb_o;
  logic [1:0]  rsrc_o;
  logic        rw_o, mw_o, br_o, j_o, jr_o, ill_o;

  decode dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .instr_dc_i      (instr),
    .pc_dc_i         (pc_in),
    .pc_next_4_dc_i  (pcn_in),
    .flush_ex_i      (flush),
    .reg_write_wb_i  (wb_en),
    .rd_wb_i         (wb_rd),
    .result_wb_i     (wb_data),
    .rs1_dc_o        (rs1_dc),
    .rs2_dc_o        (rs2_dc),
    .rs1_data_ex_o   (rs1d),
    .rs2_data_ex_o   (rs2d),
    .imm_ex_o        (imm),
    .pc_ex_o         (pc_o),
    .pc_next_4_ex_o  (pcn_o),
    .rs1_ex_o        (rs1_o),
    .rs2_ex_o        (rs2_o),
    .rd_ex_o         (rd_o),
    .funct3_ex_o     (f3_o),
    .alu_ctrl_ex_o   (aluc_o),
    .alu_src_a_ex_o  (sa_o),
    .alu_src_b_ex_o  (sb_o),
    .result_src_ex_o (rsrc_o),
    .reg_write_ex_o  (rw_o),
    .mem_write_ex_o  (mw_o),
    .branch_ex_o     (br_o),
    .jump_ex_o       (j_o),
    .jalr_ex_o       (jr_o),
    .illegal_ex_o    (ill_o)
  );

  always #5 clk = ~clk;

  ex_t   exp_q [$];
  string name_q [$];
  int    nvec  = 0;
  int    nfail = 0;
  logic [31:0] pc_cnt = 32'h0000_1000;

`ifdef DECODE_RF_BYPASS_EN
  localparam logic [31:0] SAME_CYC = 32'h1234_5678;
`else
  localparam logic [31:0] SAME_CYC = 32'h0000_0000;
`endif

  localparam logic [31:0] X3V = 32'h55AA_55AA;

  always @(negedge clk) begin
    ex_t   a;
    ex_t   e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.rs1d = rs1d;    a.rs2d = rs2d;
      a.imm  = imm;     a.pc   = pc_o;
      a.pcn  = pcn_o;   a.rs1  = rs1_o;
      a.rs2  = rs2_o;   a.rd   = rd_o;
      a.f3   = f3_o;    a.aluc = aluc_o;
      a.sa   = sa_o;    a.sb   = sb_o;
      a.rsrc = rsrc_o;  a.rw   = rw_o;
      a.mw   = mw_o;    a.br   = br_o;
      a.j    = j_o;     a.jr   = jr_o;
      a.ill  = ill_o;
      nvec++;
      if (a !== e) begin
        nfail++;
        $display("FAIL %s: got %h want %h", n, a, e);
      end
    end
  end

  // Apply one decode cycle; expectation lands on the scoreboard after the edge.
  task automatic step(input string nm, input logic [31:0] ins,
                      input logic fl, input logic rs, input ex_t e);
    instr  = ins;
    flush  = fl;
    rst    = rs;
    pc_in  = pc_cnt;
    pcn_in = pc_cnt + 32'd4;
    #1;
    nvec++;
    if (rs1_dc !== ins[19:15] || rs2_dc !== ins[24:20]) begin
      nfail++;
      $display("FAIL %s_dc: got %h/%h want %h/%h",
               nm, rs1_dc, rs2_dc, ins[19:15], ins[24:20]);
    end
    if (!fl && !rs) begin
      e.pc  = pc_cnt;
      e.pcn = pc_cnt + 32'd4;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    pc_cnt  = pc_cnt + 32'd4;
    rst     = 1'b0;
    flush   = 1'b0;
    wb_en   = 1'b0;
    wb_rd   = '0;
    wb_data = '0;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_en   = 1'b1;
    wb_rd   = r;
    wb_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    ex_t z;
    z = '0;
    #1;
    step("reset", 32'hFFF00293, 1'b0, 1'b1, z);
    step("addi", 32'hFFF00293, 1'b0, 1'b0,
         '{imm:32'hFFFF_FFFF, rs2:5'd31, rd:5'd5, sb:1'b1,
           rw:1'b1, default:'0});
    wb(5'd7, 32'h1234_5678);
    step("wb_same_cycle", 32'h000380B3, 1'b0, 1'b0,
         '{rs1d:SAME_CYC, rs1:5'd7, rd:5'd1, rw:1'b1, default:'0});
    step("wb_next_cycle", 32'h000380B3, 1'b0, 1'b0,
         '{rs1d:32'h1234_5678, rs1:5'd7, rd:5'd1, rw:1'b1,
           default:'0});
    wb(5'd0, 32'hDEAD_BEEF);
    step("x0_wb_same", 32'h000000B3, 1'b0, 1'b0,
         '{rd:5'd1, rw:1'b1, default:'0});
    step("x0_read", 32'h000000B3, 1'b0, 1'b0,
         '{rd:5'd1, rw:1'b1, default:'0});
    step("beq", 32'hFE000EE3, 1'b0, 1'b0,
         '{imm:32'hFFFF_FFFC, rd:5'd29, aluc:4'd1, br:1'b1,
           default:'0});
    wb(5'd3, X3V);
    step("flush_wb", 32'hFFF00293, 1'b1, 1'b0, z);
    step("read_x3", 32'h000180B3, 1'b0, 1'b0,
         '{rs1d:X3V, rs1:5'd3, rd:5'd1, rw:1'b1, default:'0});
    step("sub", 32'h40308133, 1'b0, 1'b0,
         '{rs2d:X3V, rs1:5'd1, rs2:5'd3, rd:5'd2, aluc:4'd1,
           rw:1'b1, default:'0});
    step("srai", 32'h4032D213, 1'b0, 1'b0,
         '{rs2d:X3V, imm:32'h0000_0403, rs1:5'd5, rs2:5'd3,
           rd:5'd4, f3:3'd5, aluc:4'd7, sb:1'b1, rw:1'b1,
           default:'0});
    step("lui", 32'h12345337, 1'b0, 1'b0,
         '{rs2d:X3V, imm:32'h1234_5000, rs1:5'd8, rs2:5'd3,
           rd:5'd6, f3:3'd5, aluc:4'd10, sb:1'b1, rw:1'b1,
           default:'0});
    step("auipc", 32'h00001497, 1'b0, 1'b0,
         '{imm:32'h0000_1000, rd:5'd9, f3:3'd1, sa:1'b1,
           sb:1'b1, rw:1'b1, default:'0});
    step("jal", 32'h008000EF, 1'b0, 1'b0,
         '{imm:32'h0000_0008, rs2:5'd8, rd:5'd1, sa:1'b1,
           sb:1'b1, rsrc:2'b10, rw:1'b1, j:1'b1, default:'0});
    step("jalr", 32'h00008067, 1'b0, 1'b0,
         '{rs1:5'd1, sb:1'b1, rsrc:2'b10, rw:1'b1, jr:1'b1,
           default:'0});
    step("lw", 32'hFF81A503, 1'b0, 1'b0,
         '{rs1d:X3V, imm:32'hFFFF_FFF8, rs1:5'd3, rs2:5'd24,
           rd:5'd10, f3:3'd2, sb:1'b1, rsrc:2'b01, rw:1'b1,
           default:'0});
    step("sw", 32'h0051A623, 1'b0, 1'b0,
         '{rs1d:X3V, imm:32'h0000_000C, rs1:5'd3, rs2:5'd5,
           rd:5'd12, f3:3'd2, sb:1'b1, mw:1'b1, default:'0});
    step("illegal", 32'h0000007F, 1'b0, 1'b0,
         '{ill:1'b1, default:'0});
    step("bubble", 32'h00000000, 1'b0, 1'b0, z);
    step("reset_pulse", 32'h000180B3, 1'b0, 1'b1, z);
    step("x3_after_rst", 32'h000180B3, 1'b0, 1'b0,
         '{rs1:5'd3, rd:5'd1, rw:1'b1, default:'0});
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      nvec++;
      nfail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
